// File: rtl/spart_pkg.sv
// spart_pkg: shared bus address map and FSM state encodings for the serial port
package spart_pkg;
  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;
endpackage

// File: rtl/spart_baud_gen.sv
// spart_baud_gen: divisor registers and down-counter producing the oversample tick en
module spart_baud_gen #(
  parameter logic [15:0] DB_RESET = 16'd324
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_lo,
  input  logic       wr_hi,
  input  logic [7:0] din,
  output logic       en
);
  logic [15:0] div, div_n, cnt;
  assign div_n = {wr_hi ? din : div[15:8], wr_lo ? din : div[7:0]};
  assign en = cnt == 16'd0;
  // a divisor write restarts the count from the new value so the rate changes at once
  always_ff @(posedge clk) begin
    if (!rst) begin
      div <= DB_RESET;
      cnt <= 16'd0;
    end else begin
      div <= div_n;
      cnt <= (wr_lo || wr_hi || en) ? div_n : cnt - 16'd1;
    end
  end
endmodule

// File: rtl/spart_rx.sv
// spart_rx: 8N1 receiver with start-bit glitch rejection, framing check and rda flag
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rxd,
  input  logic       rd_clr,
  output logic [7:0] rx_buf,
  output logic       rda
);
  localparam int CW = $clog2(OVERSAMPLE);
  logic s1, s2, s3;
  logic [1:0] st;
  logic [CW-1:0] tc;
  logic [2:0] bi;
  logic [7:0] sh;
  logic last, half, done;
  assign last = en && tc == CW'(OVERSAMPLE - 1);
  assign half = en && tc == CW'(OVERSAMPLE / 2 - 1);
  assign done = st == RX_STOP && last && s2;
  // s1/s2 synchronize rxd; s3 is the previous synchronized value for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      {s1, s2, s3} <= 3'b111;
      st <= RX_IDLE;
      tc <= '0;
      bi <= 3'd0;
      sh <= 8'd0;
      rx_buf <= 8'd0;
      rda <= 1'b0;
    end else begin
      {s1, s2, s3} <= {rxd, s1, s2};
      rda <= done ? 1'b1 : rd_clr ? 1'b0 : rda;
      if (done) rx_buf <= sh;
      case (st)
        RX_IDLE: if (s3 && !s2) begin
          st <= RX_START;
          tc <= '0;
        end
        RX_START: if (en) begin
          tc <= half ? '0 : tc + 1'b1;
          bi <= 3'd0;
          // mid start bit: a line back high means the falling edge was a glitch
          if (half) st <= s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (en) begin
          tc <= last ? '0 : tc + 1'b1;
          if (last) begin
            sh <= {s2, sh[7:1]};
            bi <= bi + 3'd1;
            if (bi == 3'd7) st <= RX_STOP;
          end
        end
        default: if (en) begin
          tc <= last ? '0 : tc + 1'b1;
          if (last) st <= RX_IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/spart_tx.sv
// spart_tx: 8N1 transmitter, one bit per OVERSAMPLE ticks, LSB first
module spart_tx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       txd,
  output logic       tbr
);
  localparam int CW = $clog2(OVERSAMPLE);
  logic [1:0] st;
  logic [CW-1:0] tc;
  logic [2:0] bi;
  logic [7:0] sh;
  logic last;
  assign last = en && tc == CW'(OVERSAMPLE - 1);
  assign txd = st == TX_START ? 1'b0 : st == TX_DATA ? sh[0] : 1'b1;
  assign tbr = st == TX_IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= TX_IDLE;
      tc <= '0;
      bi <= 3'd0;
      sh <= 8'd0;
    end else if (st == TX_IDLE) begin
      if (wr) begin
        st <= TX_START;
        sh <= din;
        tc <= '0;
        bi <= 3'd0;
      end
    end else begin
      if (en) tc <= last ? '0 : tc + 1'b1;
      if (last) begin
        st <= st == TX_START ? TX_DATA : st == TX_DATA ? (bi == 3'd7 ? TX_STOP : TX_DATA) : TX_IDLE;
        if (st == TX_DATA) begin
          sh <= sh >> 1;
          bi <= bi + 3'd1;
        end
      end
    end
  end
endmodule

// File: rtl/spart.sv
// spart: 8N1 serial port with programmable baud generator on an 8-bit tri-state bus
module spart
  import spart_pkg::*;
#(
  parameter int          OVERSAMPLE = 16,
  parameter logic [15:0] DB_RESET   = 16'd324
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  logic wr, rd, en;
  logic [7:0] rx_buf;
  assign wr = iocs && !iorw;
  assign rd = iocs && iorw;
  assign databus = rd && ioaddr == ADDR_BUF ? rx_buf : rd && ioaddr == ADDR_STAT ? {6'b0, tbr, rda} : 8'bz;
  spart_baud_gen #(.DB_RESET(DB_RESET)) u_baud (
    .clk(clk), .rst(rst), .wr_lo(wr && ioaddr == ADDR_DBL), .wr_hi(wr && ioaddr == ADDR_DBH),
    .din(databus), .en(en)
  );
  spart_tx #(.OVERSAMPLE(OVERSAMPLE)) u_tx (
    .clk(clk), .rst(rst), .en(en), .wr(wr && ioaddr == ADDR_BUF), .din(databus), .txd(txd), .tbr(tbr)
  );
  spart_rx #(.OVERSAMPLE(OVERSAMPLE)) u_rx (
    .clk(clk), .rst(rst), .en(en), .rxd(rxd), .rd_clr(rd && ioaddr == ADDR_BUF), .rx_buf(rx_buf), .rda(rda)
  );
endmodule

// File: tb/tb_spart.sv
// tb_spart: directed self-checking bench for spart with tx-bit and rx-byte scoreboards
module tb_spart;
  logic clk = 0, rst = 0, iocs = 0, iorw = 0, tb_en = 0, loop = 0, rxd_drv = 1;
  logic [1:0] ioaddr = 0;
  logic [7:0] tb_d = 0, rd_d;
  wire [7:0] databus;
  wire rda, tbr, txd, rxd;
  int checks = 0, failures = 0;
  logic exp_q[$];
  logic [7:0] rxq[$];
  assign databus = tb_en ? tb_d : 8'bz;
  assign rxd = loop ? txd : rxd_drv;
  always #5 clk = ~clk;
  spart dut (.clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
             .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd));
  task chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function logic sig(input int w);
    return w == 0 ? txd : w == 1 ? tbr : rda;
  endfunction
  task wait_sig(input int w, input logic v, input int budget, input string tag);
    int n = 0;
    while (sig(w) !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {7'b0, sig(w)}, {7'b0, v});
  endtask
  task bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1; iorw = 0; ioaddr = a; tb_d = d; tb_en = 1;
    @(posedge clk);
    #1 iocs = 0; tb_en = 0;
  endtask
  task bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1; iorw = 1; ioaddr = a;
    #1 d = databus;
    @(posedge clk);
    #1 iocs = 0; iorw = 0;
  endtask
  task send_tx(input logic [7:0] b);
    bus_write(2'b00, b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
    if (loop) rxq.push_back(b);
  endtask
  task check_tx_frame(input string tag);
    wait_sig(0, 1'b0, 200, {tag, "_start"});
    repeat (15) @(negedge clk);
    while (exp_q.size() > 0) begin
      chk(tag, {7'b0, txd}, {7'b0, exp_q.pop_front()});
      repeat (32) @(negedge clk);
    end
  endtask
  task send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (32) @(negedge clk);
    end
    rxd_drv = 1;
    repeat (32) @(negedge clk);
    if (stop) rxq.push_back(b);
  endtask
  task rx_check(input string tag);
    logic [7:0] e;
    wait_sig(2, 1'b1, 1000, {tag, "_rda"});
    e = rxq.size() > 0 ? rxq[$] : 8'hxx;
    rxq.delete();
    bus_read(2'b00, rd_d);
    chk(tag, rd_d, e);
    chk({tag, "_rda_clr"}, {7'b0, rda}, 8'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk("rst_txd", {7'b0, txd}, 8'd1);
    chk("rst_tbr", {7'b0, tbr}, 8'd1);
    chk("rst_rda", {7'b0, rda}, 8'd0);
    rst = 1;
    bus_read(2'b01, rd_d);
    chk("rst_status", rd_d, 8'h02);
    bus_write(2'b10, 8'h01);
    bus_write(2'b11, 8'h00);
    send_tx(8'h6D);
    chk("tx_tbr_busy", {7'b0, tbr}, 8'd0);
    bus_read(2'b01, rd_d);
    chk("tx_status_busy", rd_d, 8'h00);
    check_tx_frame("tx6d");
    wait_sig(1, 1'b1, 100, "tx_tbr_done");
    loop = 1;
    send_tx(8'hA5);
    check_tx_frame("txa5");
    rx_check("rx_a5");
    loop = 0;
    repeat (10) @(negedge clk);
    rxd_drv = 0;
    repeat (3) @(negedge clk);
    rxd_drv = 1;
    repeat (400) @(negedge clk);
    chk("glitch_rda", {7'b0, rda}, 8'd0);
    send_rx(8'h3C, 1'b0);
    repeat (50) @(negedge clk);
    chk("framing_rda", {7'b0, rda}, 8'd0);
    send_rx(8'h5A, 1'b1);
    rx_check("rx_5a");
    loop = 1;
    send_tx(8'h11);
    check_tx_frame("tx11");
    wait_sig(1, 1'b1, 100, "tx11_tbr");
    send_tx(8'h22);
    check_tx_frame("tx22");
    wait_sig(1, 1'b1, 100, "tx22_tbr");
    rx_check("rx_overrun");
    loop = 0;
    send_tx(8'h6D);
    bus_write(2'b00, 8'hFF);
    chk("busy_write_tbr", {7'b0, tbr}, 8'd0);
    check_tx_frame("tx_ignore");
    wait_sig(1, 1'b1, 100, "ignore_tbr");
    send_tx(8'h00);
    exp_q.delete();
    repeat (100) @(negedge clk);
    chk("mid_txd_low", {7'b0, txd}, 8'd0);
    rst = 0;
    @(posedge clk);
    #1 chk("abort_txd", {7'b0, txd}, 8'd1);
    chk("abort_tbr", {7'b0, tbr}, 8'd1);
    chk("abort_rda", {7'b0, rda}, 8'd0);
    rst = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
